// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and constants.
// Hazard FSM state, squash counter width and register-number type.
package mips_core_pkg;

    typedef logic [4:0] mips_reg;

    localparam int SQUASH_CNT_W = 3;

    typedef enum logic {
        RUN,
        RECOVER
    } hazard_state_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// Wrapping event counters for the hazard sequencer.
// Each counter adds one on every cycle its event input is high.
module hazard_perf_counters
    import mips_core_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmiss_i,
    input  logic              loaduse_i,
    input  logic              mispred_i,
    input  logic              imiss_i,
    output logic [PERF_W-1:0] dmiss_o,
    output logic [PERF_W-1:0] loaduse_o,
    output logic [PERF_W-1:0] mispred_o,
    output logic [PERF_W-1:0] imiss_o
);

    logic [PERF_W-1:0] dmiss_q, loaduse_q, mispred_q, imiss_q;

    // Count events; counters wrap naturally at 2**PERF_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmiss_q   <= '0;
            loaduse_q <= '0;
            mispred_q <= '0;
            imiss_q   <= '0;
        end else begin
            if (dmiss_i)   dmiss_q   <= dmiss_q + 1'b1;
            if (loaduse_i) loaduse_q <= loaduse_q + 1'b1;
            if (mispred_i) mispred_q <= mispred_q + 1'b1;
            if (imiss_i)   imiss_q   <= imiss_q + 1'b1;
        end
    end

    assign dmiss_o   = dmiss_q;
    assign loaduse_o = loaduse_q;
    assign mispred_o = mispred_q;
    assign imiss_o   = imiss_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: per-stage stall/flush, PC stall and redirect.
// Optional counters built when PERF_COUNTERS_EN is defined.
module hazard_sequencer
    import mips_core_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 1,
    parameter int unsigned PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_imiss,
    input  logic              i_dmiss,
    input  logic              i_dec_valid,
    input  logic              i_dec_uses_rs,
    input  mips_reg           i_dec_rs_addr,
    input  logic              i_dec_uses_rt,
    input  mips_reg           i_dec_rt_addr,
    input  logic              i_ex_is_load,
    input  logic              i_ex_uses_rw,
    input  mips_reg           i_ex_rw_addr,
    input  logic              i_ex_mispredict,
    output logic              o_pc_stall,
    output logic              o_pc_redirect,
    output logic              o_i2d_stall,
    output logic              o_i2d_flush,
    output logic              o_d2e_stall,
    output logic              o_d2e_flush,
    output logic              o_e2m_stall,
    output logic              o_e2m_flush,
    output logic              o_m2w_stall,
    output logic              o_m2w_flush,
    output logic [PERF_W-1:0] o_perf_dmiss,
    output logic [PERF_W-1:0] o_perf_loaduse,
    output logic [PERF_W-1:0] o_perf_mispred,
    output logic [PERF_W-1:0] o_perf_imiss
);

    localparam logic [SQUASH_CNT_W-1:0] SQ_LOAD =
        SQUASH_CNT_W'(SQUASH_CYCLES);

    hazard_state_t           state_q, state_d;
    logic [SQUASH_CNT_W-1:0] cnt_q, cnt_d;

    logic lu_hit;
    logic ev_dmiss, ev_mispred, ev_loaduse, ev_imiss;

    // Resolve the four hazard sources into one-hot actions by priority.
    always_comb begin
        lu_hit = i_dec_valid && i_ex_is_load && i_ex_uses_rw
              && (i_ex_rw_addr != '0)
              && ((i_dec_uses_rs && (i_dec_rs_addr == i_ex_rw_addr))
               || (i_dec_uses_rt && (i_dec_rt_addr == i_ex_rw_addr)));
        ev_dmiss   = i_dmiss;
        ev_mispred = !i_dmiss && i_ex_mispredict;
        ev_loaduse = !i_dmiss && !i_ex_mispredict && lu_hit;
        ev_imiss   = !i_dmiss && !i_ex_mispredict && !lu_hit && i_imiss;
    end

    // State and squash-count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: redirect (re)loads the count; a D-miss freezes it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ev_mispred) begin
            if (SQ_LOAD != '0) begin
                state_d = RECOVER;
                cnt_d   = SQ_LOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (state_q == RECOVER && !i_dmiss) begin
            if (cnt_q <= 3'd1) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    // Outputs: priority action, plus the refetch squash while recovering.
    always_comb begin
        o_pc_stall    = 1'b0;
        o_pc_redirect = 1'b0;
        o_i2d_stall   = 1'b0;
        o_i2d_flush   = 1'b0;
        o_d2e_stall   = 1'b0;
        o_d2e_flush   = 1'b0;
        o_e2m_stall   = 1'b0;
        o_e2m_flush   = 1'b0;
        o_m2w_stall   = 1'b0;
        o_m2w_flush   = 1'b0;
        if (rst_n) begin
            unique case (1'b1)
                ev_dmiss: begin
                    o_pc_stall  = 1'b1;
                    o_i2d_stall = 1'b1;
                    o_d2e_stall = 1'b1;
                    o_e2m_stall = 1'b1;
                    o_m2w_flush = 1'b1;
                end
                ev_mispred: begin
                    o_pc_redirect = 1'b1;
                    o_i2d_flush   = 1'b1;
                    o_d2e_flush   = 1'b1;
                end
                ev_loaduse: begin
                    o_pc_stall  = 1'b1;
                    o_i2d_stall = 1'b1;
                    o_d2e_flush = 1'b1;
                end
                ev_imiss: begin
                    o_pc_stall  = 1'b1;
                    o_i2d_flush = 1'b1;
                end
                default: ;
            endcase
            // A held I2D keeps its slot; the stale fetch is dropped anyway.
            if (state_q == RECOVER && !ev_dmiss && !ev_loaduse)
                o_i2d_flush = 1'b1;
        end
    end

`ifdef PERF_COUNTERS_EN
    hazard_perf_counters #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmiss_i   (ev_dmiss),
        .loaduse_i (ev_loaduse),
        .mispred_i (ev_mispred),
        .imiss_i   (ev_imiss),
        .dmiss_o   (o_perf_dmiss),
        .loaduse_o (o_perf_loaduse),
        .mispred_o (o_perf_mispred),
        .imiss_o   (o_perf_imiss)
    );
`else
    assign o_perf_dmiss   = '0;
    assign o_perf_loaduse = '0;
    assign o_perf_mispred = '0;
    assign o_perf_imiss   = '0;
`endif

endmodule
